// File: rtl/divider_25_9_seq_pkg.sv
// rtl/divider_25_9_seq_pkg.sv - shared widths and FSM state encoding for the 25/9 sequential divider
package divider_25_9_seq_pkg;

    localparam int DIVIDEND_W = 25;
    localparam int DIVISOR_W  = 9;
    localparam int QUOTIENT_W = 16;
    localparam int ITER_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_25_9_seq_cond_subtractor.sv
// rtl/divider_25_9_seq_cond_subtractor.sv - one restoring-division step: conditional subtract of divisor from 10-bit trial value
module cond_subtractor
    import divider_25_9_seq_pkg::*;
(
    input  logic [DIVISOR_W:0]   t,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] r_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0] diff;

    always_comb begin
        diff   = t - {1'b0, divisor};
        qbit   = (t >= {1'b0, divisor});
        // The partial remainder is always below the divisor, so 9 bits hold it.
        r_next = qbit ? diff[DIVISOR_W-1:0] : t[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/divider_25_9_seq.sv
// rtl/divider_25_9_seq.sv - sequential restoring divider, 25-bit dividend by 9-bit divisor, 16-bit quotient
module divider_25_9_seq
    import divider_25_9_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    state_t                state;
    logic [DIVISOR_W-1:0]  r;
    logic [QUOTIENT_W-1:0] q;
    logic [DIVISOR_W-1:0]  dvs;
    logic [ITER_W-1:0]     cnt;

    logic [DIVISOR_W:0]    t;
    logic [DIVISOR_W-1:0]  r_next;
    logic                  qbit;

    assign t = {r, q[QUOTIENT_W-1]};

    cond_subtractor u_cond_subtractor (
        .t       (t),
        .divisor (dvs),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvs      <= divisor;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else if (dividend[DIVIDEND_W-1:QUOTIENT_W] >= divisor) begin
                            // Quotient would need more than 16 bits.
                            state       <= S_DONE;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else begin
                            state <= S_CALC;
                            r     <= dividend[DIVIDEND_W-1:QUOTIENT_W];
                            q     <= dividend[QUOTIENT_W-1:0];
                            cnt   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r   <= r_next;
                    q   <= {q[QUOTIENT_W-2:0], qbit};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        quotient    <= {q[QUOTIENT_W-2:0], qbit};
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_25_9_seq.sv
// tb/tb_divider_25_9_seq.sv - directed and randomized self-checking bench for divider_25_9_seq
module tb_divider_25_9_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] dividend = '0;
    logic [8:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [8:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    divider_25_9_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present an operation, hold junk on the inputs after accept, and
    // report how many edges after the accept edge out_valid appeared.
    task automatic run(input logic [24:0] dd, input logic [8:0] dv, output int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        dividend = 25'h1ABCDEF;
        divisor  = 9'd3;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] eq, input logic [8:0] er,
                              input logic edz, input logic eov);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        chk({tag, "_ovf"}, overflow, eov);
    endtask

    initial begin
        int lat;
        logic [15:0] rq;
        logic [8:0]  rd, rr;
        logic [24:0] rdd;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_quot", quotient, 16'd0);
        chk("rst_rem", remainder, 9'd0);
        chk("rst_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1000 / 7 with a held-off consumer
        run(25'd1000, 9'd7, lat);
        chk("d1000_lat", lat, 16);
        chk_result("d1000", 16'd142, 9'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_quot", quotient, 16'd142);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        release_result();
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_in_ready", in_ready, 1'b1);

        // Largest non-overflowing quotient
        run(25'd33488895, 9'd511, lat);
        chk("max_lat", lat, 16);
        chk_result("max", 16'd65535, 9'd510, 1'b0, 1'b0);
        release_result();

        // Zero dividend
        run(25'd0, 9'd1, lat);
        chk("zero_lat", lat, 16);
        chk_result("zero", 16'd0, 9'd0, 1'b0, 1'b0);
        release_result();

        // Divide by zero
        run(25'd5, 9'd0, lat);
        chk("dbz_lat", lat, 0);
        chk_result("dbz", 16'hFFFF, 9'd0, 1'b1, 1'b0);
        release_result();

        // Smallest overflowing case
        run(25'h010000, 9'd1, lat);
        chk("ovf_lat", lat, 0);
        chk_result("ovf", 16'hFFFF, 9'd0, 1'b0, 1'b1);
        release_result();

        // Reset asserted at CALC iteration 8
        @(negedge clk);
        dividend = 25'd1000;
        divisor  = 9'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_quot", quotient, 16'd0);
        chk("mid_rst_rem", remainder, 9'd0);
        chk("mid_rst_flags", {div_by_zero, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        run(25'd1000, 9'd7, lat);
        chk("post_rst_lat", lat, 16);
        chk_result("post_rst", 16'd142, 9'd6, 1'b0, 1'b0);
        release_result();

        // Random operands built from a known quotient/remainder pair
        for (int n = 0; n < 2000; n++) begin
            rd  = 9'($urandom_range(1, 511));
            rq  = 16'($urandom_range(0, 65535));
            rr  = 9'($urandom_range(0, int'(rd) - 1));
            rdd = 25'(rq * rd + rr);
            run(rdd, rd, lat);
            chk("rnd_valid", out_valid, 1'b1);
            chk("rnd_identity", 32'(quotient * divisor_hold(rd) + remainder), 32'(rdd));
            chk("rnd_rem", remainder, rr);
            release_result();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic logic [31:0] divisor_hold(input logic [8:0] d);
        return {23'd0, d};
    endfunction

endmodule
